uart_echo_responder: RTL and testbench
======================================

Name: uart_echo_responder

Overview:
- FPGA-side responder for the USB-UART loopback path: deserializes bytes arriving on rx, buffers them in a FIFO, and re-serializes them on tx in arrival order.
- Acts as the far end of the host's UART link. A bench-side uart_tx drives rx, and a bench-side uart_rx monitors tx.
- Self-contained: internal RX deserializer, FIFO and TX serializer. 8N1 framing, LSB first, idle-high line.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200 baud); must be >= 4.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial in, asynchronous to clk, idle high
- tx_en  input  1  1 = transmitter may start new frames; 0 = pause after the current frame
- tx  output  1  serial out, idle high
- rx_byte  output  8  last correctly framed byte
- rx_valid  output  1  1-cycle pulse when rx_byte updates
- frame_err  output  1  1-cycle pulse when the stop bit is sampled low
- overflow  output  1  1-cycle pulse when a good byte is dropped because the FIFO is full
- fifo_count  output  FIFO_AW+1  bytes currently buffered
- tx_busy  output  1  high while a TX frame is in progress

Behaviour:
- Reset (async assert, sync release):
  - tx=1; rx_byte=0; rx_valid, frame_err, overflow, tx_busy = 0; fifo_count=0.
  - FIFO emptied; both FSMs in IDLE; rx synchronizer flops preset to 1.
  - Reset mid-frame aborts both directions immediately. tx goes high asynchronously.
- rx passes through a 2-flop synchronizer. All RX decisions use the synchronized value.
- RX FSM (R_IDLE, R_START, R_DATA, R_STOP):
  - R_IDLE: a synchronized 1->0 transition moves to R_START and clears the bit counter.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. Low -> R_DATA. High -> glitch, return to R_IDLE with no pulse.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifting LSB first. After the 8th sample -> R_STOP.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - High: rx_byte updates, rx_valid pulses, FIFO push is requested, then -> R_IDLE.
    - Low: frame_err pulses, the byte is discarded, then -> R_IDLE. Because R_IDLE needs a falling edge, a held-low line (break) starts no new frame until it returns high.
- FIFO:
  - Push is accepted only if fifo_count < 2**FIFO_AW in the push cycle; a simultaneous pop does not free space.
  - A rejected push pulses overflow in the same cycle as rx_valid.
  - Simultaneous accepted push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo depth. Order is strictly FIFO.
- TX FSM (T_IDLE, T_START, T_DATA, T_STOP):
  - T_IDLE, tx=1: if tx_en=1 and fifo_count != 0, pop the head into the shift register, set tx_busy=1, -> T_START.
  - T_START: tx=0 for CLKS_PER_BIT cycles.
  - T_DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - T_STOP: tx=1 for CLKS_PER_BIT cycles, then -> T_IDLE with tx_busy=0.
  - Back-to-back frames: the next start bit begins 1 cycle after the stop bit ends (T_IDLE lasts 1 cycle).
  - Dropping tx_en mid-frame does not truncate the frame.
- Latency, FIFO empty and tx_en=1: rx_valid in cycle N -> fifo_count=1 at N+1 -> pop at N+1 -> tx low from N+2. The total frame is exactly 10*CLKS_PER_BIT tx-low/high cycles.
- Counters are sized to hold CLKS_PER_BIT-1. No arithmetic overflow is permitted.

Test Plan:
1. Reset, tx_en=1, drive 0xAA on rx at CLKS_PER_BIT=104 -> rx_valid once with rx_byte=0xAA; tx falls 2 cycles later; bench uart_rx decodes 0xAA; frame length 1040 cycles; frame_err=0, overflow=0.
2. Back-to-back 0x55, 0xA5, 0x00, 0xFF with no idle gap -> 4 rx_valid pulses; tx returns the same 4 bytes in order; fifo_count never exceeds 1; one idle cycle between TX frames.
3. rx low for 20 cycles then high -> no rx_valid, no frame_err; FSM back in R_IDLE; a following 0x3C is received correctly.
4. Send 0x3C with the stop bit forced low -> frame_err pulses once, no rx_valid, fifo_count stays 0, tx stays high.
5. tx_en=0, send 17 bytes 0x00..0x10 -> fifo_count reaches 16; overflow pulses on byte 0x10; then tx_en=1 -> tx emits 0x00..0x0F in order and fifo_count returns to 0.
6. Assert rst_n=0 mid-TX-data-bit and mid-RX-frame -> tx=1 and fifo_count=0 immediately; after release, a fresh 0xC3 echoes correctly.

Source files
------------

// File: rtl/uart_echo_responder_if.sv
// uart_echo_responder_if: serial pins, transmit gating and status flags of the UART echo responder.
interface uart_echo_responder_if #(parameter int FIFO_AW = 4);
   logic rx;
   logic tx_en;
   logic tx;
   logic [7:0] rx_byte;
   logic rx_valid;
   logic frame_err;
   logic overflow;
   logic [FIFO_AW:0] fifo_count;
   logic tx_busy;
   modport master (output rx, tx_en, input tx, rx_byte, rx_valid, frame_err, overflow, fifo_count, tx_busy);
   modport slave (input rx, tx_en, output tx, rx_byte, rx_valid, frame_err, overflow, fifo_count, tx_busy);
endinterface

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: 8N1 UART receiver feeding a FIFO that is re-serialized on tx in arrival order.
module uart_echo_responder #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_AW = 4
) (
   input logic clk,
   input logic rst_n,
   uart_echo_responder_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} t_state_t;
   r_state_t r_state, r_next;
   t_state_t t_state, t_next;
   logic rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] r_cnt, r_cnt_next, t_cnt, t_cnt_next;
   logic [2:0] r_bit, r_bit_next, t_bit, t_bit_next;
   logic [7:0] r_shift, r_shift_next, t_shift, t_shift_next;
   logic r_good, r_bad;
   logic [7:0] rx_byte;
   logic rx_valid, frame_err, tx, tx_d, tx_busy;
   logic [7:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0] count;
   logic push, pop;
   assign push = rx_valid && count != FULL;
   assign bus.overflow = rx_valid && count == FULL;
   assign bus.rx_byte = rx_byte;
   assign bus.rx_valid = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.fifo_count = count;
   assign bus.tx = tx;
   assign bus.tx_busy = tx_busy;
   always_comb begin
      r_next = r_state;
      r_cnt_next = r_cnt + 1'b1;
      r_bit_next = r_bit;
      r_shift_next = r_shift;
      r_good = 1'b0;
      r_bad = 1'b0;
      case (r_state)
         R_IDLE: begin
            r_cnt_next = '0;
            if (rx_prev && !rx_sync) begin
               r_next = R_START;
               r_bit_next = '0;
            end
         end
         R_START: if (r_cnt == HALF_END) begin
            r_cnt_next = '0;
            r_next = rx_sync ? R_IDLE : R_DATA;
         end
         R_DATA: if (r_cnt == BIT_END) begin
            r_cnt_next = '0;
            r_shift_next = {rx_sync, r_shift[7:1]};
            r_bit_next = r_bit + 1'b1;
            r_next = r_bit == 3'd7 ? R_STOP : R_DATA;
         end
         R_STOP: if (r_cnt == BIT_END) begin
            r_cnt_next = '0;
            r_next = R_IDLE;
            r_good = rx_sync;
            r_bad = !rx_sync;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         r_state <= R_IDLE;
         r_cnt <= '0;
         r_bit <= '0;
         r_shift <= '0;
         rx_byte <= '0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta <= bus.rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         r_state <= r_next;
         r_cnt <= r_cnt_next;
         r_bit <= r_bit_next;
         r_shift <= r_shift_next;
         rx_valid <= r_good;
         frame_err <= r_bad;
         if (r_good) rx_byte <= r_shift;
      end
   // Full is judged on the current count only; a same-cycle pop never makes room for a push.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + FIFO_AW'(push);
         rd_ptr <= rd_ptr + FIFO_AW'(pop);
         count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= rx_byte;
   always_comb begin
      t_next = t_state;
      t_cnt_next = t_cnt + 1'b1;
      t_bit_next = t_bit;
      t_shift_next = t_shift;
      pop = 1'b0;
      case (t_state)
         T_IDLE: begin
            t_cnt_next = '0;
            t_bit_next = '0;
            if (bus.tx_en && count != '0) begin
               pop = 1'b1;
               t_shift_next = mem[rd_ptr];
               t_next = T_START;
            end
         end
         T_START: if (t_cnt == BIT_END) begin
            t_cnt_next = '0;
            t_next = T_DATA;
         end
         T_DATA: if (t_cnt == BIT_END) begin
            t_cnt_next = '0;
            t_shift_next = t_shift >> 1;
            t_bit_next = t_bit + 1'b1;
            t_next = t_bit == 3'd7 ? T_STOP : T_DATA;
         end
         T_STOP: if (t_cnt == BIT_END) begin
            t_cnt_next = '0;
            t_next = T_IDLE;
         end
      endcase
      tx_d = t_next == T_START ? 1'b0 : t_next == T_DATA ? t_shift_next[0] : 1'b1;
   end
   // tx is registered from the next state so the line is glitch-free and presets high on reset.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         t_state <= T_IDLE;
         t_cnt <= '0;
         t_bit <= '0;
         t_shift <= '0;
         tx <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         t_state <= t_next;
         t_cnt <= t_cnt_next;
         t_bit <= t_bit_next;
         t_shift <= t_shift_next;
         tx <= tx_d;
         tx_busy <= t_next != T_IDLE;
      end
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: directed loopback bench; stimulus queues expected bytes, monitors decode and compare.
module tb_uart_echo_responder;
   localparam int CLKS = 104;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int tests = 0, fails = 0, cyc = 0;
   int last_rxv = 0, rxv_cnt = 0, err_cnt = 0, ovf_cnt = 0, max_cnt = 0;
   logic [7:0] ovf_byte = '0;
   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];
   int tx_starts[$];
   uart_echo_responder_if #(.FIFO_AW(4)) bus();
   uart_echo_responder #(.CLKS_PER_BIT(CLKS), .FIFO_AW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask
   task automatic send_byte(input logic [7:0] d, input logic stop);
      bus.rx = 1'b0;
      repeat (CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         repeat (CLKS) @(negedge clk);
      end
      bus.rx = stop;
      repeat (CLKS) @(negedge clk);
   endtask
   task automatic expect_echo(input logic [7:0] d);
      rx_exp.push_back(d);
      tx_exp.push_back(d);
      send_byte(d, 1'b1);
   endtask
   task automatic wait_done(input int budget);
      int n = 0;
      while ((tx_exp.size() != 0 || bus.tx_busy || bus.fifo_count != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         tests++;
         fails++;
         $display("FAIL wait_done: timeout after %0d cycles, %0d tx bytes outstanding", n, tx_exp.size());
      end
      repeat (5) @(negedge clk);
   endtask
   task automatic clear_stats();
      rxv_cnt = 0;
      err_cnt = 0;
      ovf_cnt = 0;
      max_cnt = 0;
      tx_starts.delete();
   endtask
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
         if (bus.frame_err) err_cnt++;
         if (bus.overflow) begin
            ovf_cnt++;
            ovf_byte = bus.rx_byte;
         end
         if (bus.rx_valid) begin
            rxv_cnt++;
            last_rxv = cyc;
            if (rx_exp.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rx_unexpected: got %0h expected no rx_valid", bus.rx_byte);
            end else chk("rx_byte", bus.rx_byte, rx_exp.pop_front());
         end
      end
   end
   initial begin : tx_mon
      logic prev;
      logic [7:0] d;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && prev && !bus.tx) begin
            tx_starts.push_back(cyc);
            d = '0;
            for (int k = 1; k <= 10 * CLKS; k++) begin
               @(negedge clk);
               if (!rst_n) break;
               if (k % CLKS == CLKS / 2) begin
                  int i;
                  i = k / CLKS;
                  if (i == 0) chk("tx_start_bit", bus.tx, 0);
                  else if (i <= 8) d[i-1] = bus.tx;
                  else begin
                     chk("tx_stop_bit", bus.tx, 1);
                     if (tx_exp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL tx_unexpected: got %0h expected no frame", d);
                     end else chk("tx_byte", d, tx_exp.pop_front());
                  end
               end
               if (k == 10 * CLKS - 1) chk("tx_frame_tail", {bus.tx_busy, bus.tx}, 2'b11);
               if (k == 10 * CLKS) chk("tx_frame_len", bus.tx_busy, 0);
            end
         end
         prev = bus.tx;
      end
   end
   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before cycle 90000");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.rx = 1'b1;
      bus.tx_en = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_tx", bus.tx, 1);
      chk("rst_rx_byte", bus.rx_byte, 0);
      chk("rst_pulses", {bus.rx_valid, bus.frame_err, bus.overflow, bus.tx_busy}, 0);
      chk("rst_fifo_count", bus.fifo_count, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      // 1: single byte echo with latency and frame length
      clear_stats();
      expect_echo(8'hAA);
      wait_done(3000);
      chk("t1_rx_valid_count", rxv_cnt, 1);
      chk("t1_frame_err", err_cnt, 0);
      chk("t1_overflow", ovf_cnt, 0);
      chk("t1_tx_frames", tx_starts.size(), 1);
      if (tx_starts.size() > 0) chk("t1_latency", tx_starts[0] - last_rxv, 2);
      // 2: back-to-back bytes
      clear_stats();
      expect_echo(8'h55);
      expect_echo(8'hA5);
      expect_echo(8'h00);
      expect_echo(8'hFF);
      wait_done(3000);
      chk("t2_rx_valid_count", rxv_cnt, 4);
      chk("t2_max_fifo", max_cnt, 1);
      chk("t2_tx_frames", tx_starts.size(), 4);
      if (tx_starts.size() >= 4)
         for (int i = 1; i < 4; i++) chk("t2_frame_gap", tx_starts[i] - tx_starts[i-1], 10 * CLKS + 1);
      // 3: short glitch then a real byte
      clear_stats();
      bus.rx = 1'b0;
      repeat (20) @(negedge clk);
      bus.rx = 1'b1;
      repeat (200) @(negedge clk);
      chk("t3_glitch_rx_valid", rxv_cnt, 0);
      chk("t3_glitch_frame_err", err_cnt, 0);
      expect_echo(8'h3C);
      wait_done(3000);
      chk("t3_rx_valid_count", rxv_cnt, 1);
      // 4: stop bit low
      clear_stats();
      send_byte(8'h3C, 1'b0);
      bus.rx = 1'b1;
      repeat (300) @(negedge clk);
      chk("t4_frame_err", err_cnt, 1);
      chk("t4_rx_valid", rxv_cnt, 0);
      chk("t4_max_fifo", max_cnt, 0);
      chk("t4_tx_frames", tx_starts.size(), 0);
      chk("t4_tx_idle", bus.tx, 1);
      // 5: fill with transmitter paused, one overflow, then drain
      clear_stats();
      bus.tx_en = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         rx_exp.push_back(8'(i));
         if (i < 16) tx_exp.push_back(8'(i));
         send_byte(8'(i), 1'b1);
      end
      repeat (10) @(negedge clk);
      chk("t5_fifo_full", bus.fifo_count, 16);
      chk("t5_max_fifo", max_cnt, 16);
      chk("t5_overflow_count", ovf_cnt, 1);
      chk("t5_overflow_byte", ovf_byte, 8'h10);
      chk("t5_tx_paused", tx_starts.size(), 0);
      bus.tx_en = 1'b1;
      wait_done(20000);
      chk("t5_fifo_drained", bus.fifo_count, 0);
      chk("t5_tx_frames", tx_starts.size(), 16);
      if (tx_starts.size() == 16) chk("t5_frame_gap", tx_starts[15] - tx_starts[14], 10 * CLKS + 1);
      // 6: reset in the middle of both directions
      clear_stats();
      expect_echo(8'h81);
      fork
         send_byte(8'h7E, 1'b1);
      join_none
      repeat (3 * CLKS + 10) @(negedge clk);
      chk("t6_mid_tx_busy", bus.tx_busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_tx", bus.tx, 1);
      chk("t6_rst_fifo", bus.fifo_count, 0);
      chk("t6_rst_busy", bus.tx_busy, 0);
      tx_exp.delete();
      rx_exp.delete();
      repeat (7 * CLKS + 20) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      clear_stats();
      expect_echo(8'hC3);
      wait_done(3000);
      chk("t6_rx_valid_count", rxv_cnt, 1);
      chk("t6_tx_frames", tx_starts.size(), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
